// File: rtl/exidy2_dl_loader_if.sv
// Download bus between hps_io and the exidy2 loader.
// Carries the ioctl byte stream in and the ROM region write port out.
interface exidy2_dl_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        prg_we;
    logic        chr_we;
    logic        snd_we;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  prg_we, chr_we, snd_we, rom_addr, rom_data
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output prg_we, chr_we, snd_we, rom_addr, rom_data
    );
endinterface

// File: rtl/exidy2_dl_loader.sv
// Demuxes the ioctl ROM stream into exidy2 PRG/CHR/SND write ports,
// captures DIP/mod bytes and sequences the core reset around downloads.
module exidy2_dl_loader #(
    parameter logic [31:0] PRG_SIZE   = 32'h0A000,
    parameter logic [31:0] CHR_SIZE   = 32'h01000,
    parameter logic [31:0] SND_SIZE   = 32'h01000,
    parameter int          SETTLE_CYC = 16
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    exidy2_dl_loader_if.slave         bus,
    input  logic                      rst_req,
    output logic [7:0]                mod_other,
    output logic [7:0]                mod_shift,
    output logic [63:0]               dip_sw,
    output logic                      core_reset,
    output logic                      dl_done,
    output logic                      dl_overflow,
    output logic [24:0]               dl_bytes
);
    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam logic [31:0] CHR_BASE = PRG_SIZE;
    localparam logic [31:0] SND_BASE = PRG_SIZE + CHR_SIZE;
    localparam logic [31:0] ROM_END  = PRG_SIZE + CHR_SIZE + SND_SIZE;

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prg_we_q, prg_we_d;
    logic          chr_we_q, chr_we_d;
    logic          snd_we_q, snd_we_d;
    logic [16:0]   rom_addr_q, rom_addr_d;
    logic [7:0]    rom_data_q, rom_data_d;
    logic [7:0]    mod_other_q, mod_other_d;
    logic [7:0]    mod_shift_q, mod_shift_d;
    logic [63:0]   dip_q, dip_d;
    logic          core_reset_q, core_reset_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic [24:0]   bytes_q, bytes_d;
    logic          idx_zero;
    logic          start;
    logic          rom_ok;
    logic [31:0]   a32;

    assign idx_zero = (bus.ioctl_index == 8'd0);
    assign a32      = {7'd0, bus.ioctl_addr};

    // Next-state: stream demux, side-channel capture and load sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prg_we_d    = 1'b0;
        chr_we_d    = 1'b0;
        snd_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_data_d  = rom_data_q;
        mod_other_d = mod_other_q;
        mod_shift_d = mod_shift_q;
        dip_d       = dip_q;
        ovf_d       = ovf_q;
        bytes_d     = bytes_q;
        // A new ROM download may begin from any state but LOAD; its first
        // byte can arrive in the very cycle we notice it.
        start  = bus.ioctl_download && idx_zero && (state_q != LOAD);
        rom_ok = bus.ioctl_wr && idx_zero && ((state_q == LOAD) || start);

        if (start) begin
            state_d = LOAD;
            bytes_d = '0;
            ovf_d   = 1'b0;
        end

        if (rom_ok) begin
            if (a32 < CHR_BASE) begin
                prg_we_d   = 1'b1;
                rom_addr_d = 17'(a32);
                rom_data_d = bus.ioctl_dout;
            end else if (a32 < SND_BASE) begin
                chr_we_d   = 1'b1;
                rom_addr_d = 17'(a32 - CHR_BASE);
                rom_data_d = bus.ioctl_dout;
            end else if (a32 < ROM_END) begin
                snd_we_d   = 1'b1;
                rom_addr_d = 17'(a32 - SND_BASE);
                rom_data_d = bus.ioctl_dout;
            end else begin
                ovf_d = 1'b1;
            end
            if (bytes_d != '1) begin
                bytes_d = bytes_d + 25'd1;
            end
        end

        if (bus.ioctl_wr) begin
            case (bus.ioctl_index)
                8'd1:    mod_other_d = bus.ioctl_dout;
                8'd2:    mod_shift_d = bus.ioctl_dout;
                8'd254: begin
                    if (bus.ioctl_addr[24:3] == '0) begin
                        dip_d[{bus.ioctl_addr[2:0], 3'b000} +: 8] = bus.ioctl_dout;
                    end
                end
                default: ;
            endcase
        end

        if (!start) begin
            unique case (state_q)
                IDLE: ;
                LOAD: begin
                    if (!bus.ioctl_download) begin
                        if (bytes_d == '0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = SETTLE;
                            cnt_d   = '0;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: ;
            endcase
        end

        core_reset_d = (state_d == RUN) ? rst_req : 1'b1;
        done_d       = (state_d == RUN);
    end

    // State and all outputs registered; async reset parks the core in reset.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            prg_we_q     <= 1'b0;
            chr_we_q     <= 1'b0;
            snd_we_q     <= 1'b0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            mod_other_q  <= '0;
            mod_shift_q  <= '0;
            dip_q        <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            bytes_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prg_we_q     <= prg_we_d;
            chr_we_q     <= chr_we_d;
            snd_we_q     <= snd_we_d;
            rom_addr_q   <= rom_addr_d;
            rom_data_q   <= rom_data_d;
            mod_other_q  <= mod_other_d;
            mod_shift_q  <= mod_shift_d;
            dip_q        <= dip_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            bytes_q      <= bytes_d;
        end
    end

    assign bus.prg_we   = prg_we_q;
    assign bus.chr_we   = chr_we_q;
    assign bus.snd_we   = snd_we_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_data = rom_data_q;
    assign mod_other    = mod_other_q;
    assign mod_shift    = mod_shift_q;
    assign dip_sw       = dip_q;
    assign core_reset   = core_reset_q;
    assign dl_done      = done_q;
    assign dl_overflow  = ovf_q;
    assign dl_bytes     = bytes_q;
endmodule

// File: tb/tb_exidy2_dl_loader.sv
// Bench for exidy2_dl_loader: per-cycle comparison against a
// spec-level model plus literal checks on counts and timings.
module tb_exidy2_dl_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_req = 1'b0;
    logic [7:0]  mod_other, mod_shift;
    logic [63:0] dip_sw;
    logic        core_reset, dl_done, dl_overflow;
    logic [24:0] dl_bytes;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    exidy2_dl_loader_if bus();

    exidy2_dl_loader dut (
        .clk_sys     (clk),
        .reset       (rst),
        .bus         (bus),
        .rst_req     (rst_req),
        .mod_other   (mod_other),
        .mod_shift   (mod_shift),
        .dip_sw      (dip_sw),
        .core_reset  (core_reset),
        .dl_done     (dl_done),
        .dl_overflow (dl_overflow),
        .dl_bytes    (dl_bytes)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Spec-level model: region from address arithmetic, settle as an edge count.
    logic        m_prg = 0, m_chr = 0, m_snd = 0;
    logic [16:0] m_addr = 0;
    logic [7:0]  m_data = 0, m_mo = 0, m_ms = 0;
    logic [63:0] m_dip = 0;
    logic [24:0] m_bytes = 0;
    logic        m_ovf = 0, m_done = 0, m_cr = 1, m_loading = 0;
    int          m_settle = -1;
    int          m_a;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prg = 0; m_chr = 0; m_snd = 0; m_addr = 0; m_data = 0;
            m_mo = 0; m_ms = 0; m_dip = 0; m_bytes = 0; m_ovf = 0;
            m_done = 0; m_cr = 1; m_loading = 0; m_settle = -1;
        end else begin
            m_a = int'(bus.ioctl_addr);
            m_prg = 0; m_chr = 0; m_snd = 0;
            if (bus.ioctl_download && bus.ioctl_index == 0 && !m_loading) begin
                m_loading = 1; m_bytes = 0; m_ovf = 0; m_done = 0; m_settle = -1;
            end
            if (bus.ioctl_wr && bus.ioctl_index == 0 && m_loading) begin
                if (m_a < 'hA000) begin
                    m_prg = 1; m_addr = 17'(m_a); m_data = bus.ioctl_dout;
                end else if (m_a < 'hB000) begin
                    m_chr = 1; m_addr = 17'(m_a - 'hA000); m_data = bus.ioctl_dout;
                end else if (m_a < 'hC000) begin
                    m_snd = 1; m_addr = 17'(m_a - 'hB000); m_data = bus.ioctl_dout;
                end else begin
                    m_ovf = 1;
                end
                if (m_bytes != 25'h1FFFFFF) m_bytes = m_bytes + 1;
            end
            if (bus.ioctl_wr && bus.ioctl_index == 1) m_mo = bus.ioctl_dout;
            if (bus.ioctl_wr && bus.ioctl_index == 2) m_ms = bus.ioctl_dout;
            if (bus.ioctl_wr && bus.ioctl_index == 254 && m_a < 8)
                m_dip[m_a*8 +: 8] = bus.ioctl_dout;
            if (m_loading && !bus.ioctl_download) begin
                m_loading = 0;
                m_settle = (m_bytes == 0) ? -1 : 0;
            end else if (m_settle >= 0) begin
                m_settle++;
                if (m_settle == 16) begin
                    m_done = 1; m_settle = -1;
                end
            end
            m_cr = m_done ? rst_req : 1'b1;
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        chk("we", {61'd0, bus.prg_we, bus.chr_we, bus.snd_we},
            {61'd0, m_prg, m_chr, m_snd});
        chk("rom_addr", 64'(bus.rom_addr), 64'(m_addr));
        chk("rom_data", 64'(bus.rom_data), 64'(m_data));
        chk("dl_bytes", 64'(dl_bytes), 64'(m_bytes));
        chk("dl_overflow", 64'(dl_overflow), 64'(m_ovf));
        chk("core_reset", 64'(core_reset), 64'(m_cr));
        chk("dl_done", 64'(dl_done), 64'(m_done));
        chk("dip_sw", dip_sw, m_dip);
        chk("mods", {48'd0, mod_other, mod_shift}, {48'd0, m_mo, m_ms});
    end

    // Pulse tallies straight from the DUT, for literal region-size checks.
    int n_prg = 0, n_chr = 0, n_snd = 0;
    logic chr_seen = 0;
    logic [16:0] chr_first_addr = '1;
    always @(negedge clk) begin
        if (bus.prg_we) n_prg++;
        if (bus.chr_we) n_chr++;
        if (bus.snd_we) n_snd++;
        if (bus.chr_we && !chr_seen) begin
            chr_seen = 1;
            chr_first_addr = bus.rom_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int p0, c0, s0, n, first_k;

    initial begin
        bus.ioctl_download = 0; bus.ioctl_wr = 0; bus.ioctl_addr = 0;
        bus.ioctl_dout = 0; bus.ioctl_index = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_dl_done", 64'(dl_done), 64'd0);
        chk("rst_dl_bytes", 64'(dl_bytes), 64'd0);
        step(); rst = 0;

        // Load aborted by reset at byte 0x500.
        step(); bus.ioctl_download = 1; bus.ioctl_index = 0;
        for (int i = 0; i < 'h500; i++) begin
            step(); bus.ioctl_wr = 1;
            bus.ioctl_addr = 25'(i); bus.ioctl_dout = 8'(i);
        end
        step(); rst = 1; bus.ioctl_wr = 0; bus.ioctl_download = 0;
        @(negedge clk);
        chk("abort_core_reset", 64'(core_reset), 64'd1);
        chk("abort_dl_done", 64'(dl_done), 64'd0);
        chk("abort_dl_bytes", 64'(dl_bytes), 64'd0);
        step(); rst = 0;
        step();

        // Full image plus 4 overflow bytes.
        p0 = n_prg; c0 = n_chr; s0 = n_snd;
        step(); bus.ioctl_download = 1; bus.ioctl_index = 0;
        for (int i = 0; i < 'hC004; i++) begin
            step();
            if (i == 'hC000) begin
                chk("full_dl_bytes", 64'(dl_bytes), 64'hC000);
                chk("full_no_ovf", 64'(dl_overflow), 64'd0);
            end
            bus.ioctl_wr = 1;
            bus.ioctl_addr = 25'(i); bus.ioctl_dout = 8'(i);
        end
        step(); bus.ioctl_wr = 0; bus.ioctl_download = 0;
        @(posedge clk);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (core_reset) n++;
            else break;
        end
        chk("settle_cycles", 64'(n), 64'd16);
        chk("run_dl_done", 64'(dl_done), 64'd1);
        chk("prg_pulses", 64'(n_prg - p0), 64'hA000);
        chk("chr_pulses", 64'(n_chr - c0), 64'h1000);
        chk("snd_pulses", 64'(n_snd - s0), 64'h1000);
        chk("chr_first_addr", 64'(chr_first_addr), 64'd0);
        chk("ovf_set", 64'(dl_overflow), 64'd1);
        chk("ovf_dl_bytes", 64'(dl_bytes), 64'hC004);

        // DIP bytes (addr 8 ignored) and mod bytes while running.
        step(); bus.ioctl_download = 1; bus.ioctl_index = 254;
        for (int i = 0; i < 9; i++) begin
            step(); bus.ioctl_wr = 1; bus.ioctl_addr = 25'(i);
            bus.ioctl_dout = (i < 8) ? 8'((i + 1) * 'h11) : 8'hFF;
        end
        step(); bus.ioctl_index = 1; bus.ioctl_addr = 0; bus.ioctl_dout = 8'h05;
        step(); bus.ioctl_index = 2; bus.ioctl_dout = 8'hA5;
        step(); bus.ioctl_wr = 0; bus.ioctl_download = 0;
        step();
        @(negedge clk);
        chk("dip_lit", dip_sw, 64'h8877665544332211);
        chk("mod_other_lit", 64'(mod_other), 64'h05);
        chk("mod_shift_lit", 64'(mod_shift), 64'hA5);
        chk("side_core_reset", 64'(core_reset), 64'd0);
        chk("side_dl_done", 64'(dl_done), 64'd1);

        // rst_req held for 3 cycles in RUN.
        step(); rst_req = 1;
        n = 0; first_k = -1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (k == 2) rst_req = 0;
            @(negedge clk);
            if (core_reset) begin
                n++;
                if (first_k < 0) first_k = k;
            end
        end
        chk("rst_req_cycles", 64'(n), 64'd3);
        chk("rst_req_latency", 64'(first_k), 64'd0);
        chk("rst_req_done", 64'(dl_done), 64'd1);

        // Short reload, last byte written as download falls.
        p0 = n_prg;
        step(); bus.ioctl_download = 1; bus.ioctl_index = 0;
        for (int i = 0; i < 16; i++) begin
            step(); bus.ioctl_wr = 1;
            bus.ioctl_addr = 25'(i); bus.ioctl_dout = 8'(i);
            if (i == 15) bus.ioctl_download = 0;
        end
        step(); bus.ioctl_wr = 0;
        n = 0;
        while (!dl_done && n < 40) begin
            step(); n++;
        end
        chk("reload_done", 64'(dl_done), 64'd1);
        chk("reload_ovf_clr", 64'(dl_overflow), 64'd0);
        chk("reload_bytes", 64'(dl_bytes), 64'h10);
        chk("reload_prg", 64'(n_prg - p0), 64'h10);

        // Empty download returns to idle with the core held.
        step(); bus.ioctl_download = 1; bus.ioctl_index = 0;
        repeat (3) step();
        bus.ioctl_download = 0;
        repeat (30) step();
        @(negedge clk);
        chk("empty_core_reset", 64'(core_reset), 64'd1);
        chk("empty_dl_done", 64'(dl_done), 64'd0);
        chk("empty_dl_bytes", 64'(dl_bytes), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
